// File: rtl/cpu_program_feeder.sv
// Instruction feeder for the CPU: a host loads a program into a buffer, and a run
// pulses CPU start and then streams one word per cycle until HALT. The optional
// NOP padding between instructions is enabled by defining FEEDER_NOP_PAD_EN.
module cpu_program_feeder #(
    parameter int         AW      = 8,
    parameter logic [4:0] HALT_OP = 5'b00001,
    parameter logic [4:0] NOP_OP  = 5'b00000,
    parameter int         NOP_PAD = 3
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [15:0]   ld_data_i,
    input  logic          ld_clear_i,
    input  logic          run_i,
    output logic          enable_o,
    output logic          start_o,
    output logic [15:0]   i_datain_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW:0]   prog_len_o
);

    localparam int          Depth    = 2 ** AW;
    localparam logic [15:0] NopWord  = {NOP_OP, 11'b0};
    localparam logic [15:0] HaltWord = {HALT_OP, 11'b0};

    typedef enum logic [2:0] {
        Idle,
        Start,
        Issue,
        Done
`ifdef FEEDER_NOP_PAD_EN
        , Pad
`endif
    } state_e;

    state_e        state_q;
    logic          enable_q;
    logic          start_q;
    logic [15:0]   word_q;
    logic          busy_q;
    logic          done_q;
    logic [AW:0]   progLen_q;
    logic [AW:0]   progLen_d;
    logic [AW:0]   ptr_q;
    logic [AW:0]   ptrInc;
    logic [AW:0]   ldAddrPlus1;
    logic          loadOk;
    logic [15:0]   fetchCur;
    logic [15:0]   mem_q [Depth];
`ifdef FEEDER_NOP_PAD_EN
    logic [2:0]    padCnt_q;
`else
    logic [15:0]   fetchNext;
`endif

    // Words past the loaded program read as a synthesized HALT so a run always terminates.
    always_comb begin
        loadOk      = (state_q == Idle) || (state_q == Done);
        ldAddrPlus1 = (AW + 1)'(ld_addr_i) + (AW + 1)'(1);
        ptrInc      = ptr_q + (AW + 1)'(1);
        progLen_d   = progLen_q;
        if (loadOk) begin
            if (ld_clear_i) begin
                progLen_d = '0;
            end else if (ld_we_i && (ldAddrPlus1 > progLen_q)) begin
                progLen_d = ldAddrPlus1;
            end
        end
        fetchCur = (ptr_q == progLen_q) ? HaltWord : mem_q[ptr_q[AW-1:0]];
`ifndef FEEDER_NOP_PAD_EN
        fetchNext = (ptrInc == progLen_q) ? HaltWord : mem_q[ptrInc[AW-1:0]];
`endif
    end

    always_ff @(posedge clock_i) begin
        if (reset_ni && loadOk && ld_we_i && !ld_clear_i) begin
            mem_q[ld_addr_i] <= ld_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q   <= Idle;
            enable_q  <= 1'b0;
            start_q   <= 1'b0;
            word_q    <= NopWord;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            progLen_q <= '0;
            ptr_q     <= '0;
`ifdef FEEDER_NOP_PAD_EN
            padCnt_q  <= '0;
`endif
        end else begin
            progLen_q <= progLen_d;
            unique case (state_q)
                Idle, Done: begin
                    if (run_i) begin
                        state_q  <= Start;
                        enable_q <= 1'b1;
                        start_q  <= 1'b1;
                        word_q   <= NopWord;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        ptr_q    <= '0;
                    end
                end
                Start: begin
                    state_q <= Issue;
                    start_q <= 1'b0;
                    word_q  <= fetchCur;
                end
                // The word on the output decides what follows it, including a synthesized HALT.
                Issue: begin
                    if (word_q[15:11] == HALT_OP) begin
                        state_q <= Done;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        word_q  <= NopWord;
                    end else begin
                        ptr_q <= ptrInc;
`ifdef FEEDER_NOP_PAD_EN
                        state_q  <= Pad;
                        word_q   <= NopWord;
                        padCnt_q <= 3'(NOP_PAD - 1);
`else
                        word_q <= fetchNext;
`endif
                    end
                end
`ifdef FEEDER_NOP_PAD_EN
                Pad: begin
                    if (padCnt_q == 3'd0) begin
                        state_q <= Issue;
                        word_q  <= fetchCur;
                    end else begin
                        padCnt_q <= padCnt_q - 3'd1;
                    end
                end
`endif
                default: begin
                    state_q  <= Idle;
                    enable_q <= 1'b0;
                    start_q  <= 1'b0;
                    word_q   <= NopWord;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign enable_o   = enable_q;
    assign start_o    = start_q;
    assign i_datain_o = word_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign prog_len_o = progLen_q;

endmodule
